// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// mmio_pkg
//   Shared types and constants for the transaction-based MMIO bus controller.
//   Contents: FSM state type, slot-index width helper, error read-data value.
//   Revision: 1.0 - initial release
// ============================================================================
package mmio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } mmio_state_t;

   // Bits needed to index n items (at least 1).
   function automatic int slot_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Slot-index width for the full 64-slot map.
   localparam int MMIO_SLOT_AW_DEF = slot_idx_w(64);

   // Read data returned on errors and writes; sliced to the bus width by users.
   localparam int                     MMIO_MAX_DW   = 256;
   localparam logic [MMIO_MAX_DW-1:0] MMIO_ERR_DATA = '0;

endpackage
`default_nettype wire

// File: rtl/mmio_timeout.sv
`default_nettype none
// ============================================================================
// mmio_timeout
//   Wait-cycle counter for the MMIO controller. Cleared while the controller
//   is idle, counts once per enabled cycle; `expired` is high during the
//   TIMEOUT-th enabled cycle so the controller can leave WAIT on that edge.
//   Ports: clock, reset (sync, active-high), clear, enable, expired.
//   Revision: 1.0 - initial release
// ============================================================================
module mmio_timeout
   import mmio_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CW      = (slot_idx_w(TIMEOUT + 1) > 8) ? slot_idx_w(TIMEOUT + 1) : 8
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // count holds the number of WAIT cycles already completed.
   assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// mmio_bus_ctrl
//   Transaction-based MMIO controller between the fpro bridge and N_SLOTS
//   peripheral slots. One request at a time; only the addressed slot is
//   strobed; completion waits for that slot's acknowledge. Bad slot indices
//   and simultaneous read+write complete immediately with mmio_error.
//   Optional macro MMIO_TIMEOUT_EN bounds the WAIT state to TIMEOUT cycles.
//   Ports:
//     clock, reset                    - clock, sync active-high reset
//     mmio_cs/address/write_data/
//       write/read                    - bridge request
//     mmio_read_data/ready/error/busy - bridge response / status
//     slot_cs/write/read              - one-hot slot select and strobes
//     slot_reg_addr/write_data        - shared latched register addr / data
//     slot_read_data/ack              - per-slot response
//   Revision: 1.0 - initial release
// ============================================================================
module mmio_bus_ctrl
   import mmio_pkg::*;
#(
   parameter int N_SLOTS = 64,
   parameter int ADDR_W  = 21,
   parameter int REG_AW  = 5,
   parameter int SLOT_AW = MMIO_SLOT_AW_DEF,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         mmio_cs,
   input  logic [ADDR_W-1:0]            mmio_address,
   input  logic [DW-1:0]                mmio_write_data,
   input  logic                         mmio_write,
   input  logic                         mmio_read,
   output logic [DW-1:0]                mmio_read_data,
   output logic                         mmio_ready,
   output logic                         mmio_error,
   output logic                         mmio_busy,
   output logic [N_SLOTS-1:0]           slot_cs,
   output logic [REG_AW-1:0]            slot_reg_addr,
   output logic [DW-1:0]                slot_write_data,
   output logic [N_SLOTS-1:0]           slot_write,
   output logic [N_SLOTS-1:0]           slot_read,
   input  logic [N_SLOTS-1:0][DW-1:0]   slot_read_data,
   input  logic [N_SLOTS-1:0]           slot_ack
);

   mmio_state_t          state, state_next;
   logic [SLOT_AW-1:0]   slot_idx;
   logic                 op_read;
   logic                 err_flag;
   logic [N_SLOTS-1:0]   slot_onehot;
   logic [DW-1:0]        sel_data;
   logic                 sel_ack;
   logic                 timed_out;
   logic                 unused_ok;

   wire [SLOT_AW-1:0] req_slot = mmio_address[REG_AW +: SLOT_AW];
   wire               trigger  = mmio_cs & (mmio_read | mmio_write);
   wire               bad_req  = (mmio_read & mmio_write) |
                                 (32'(req_slot) >= 32'(N_SLOTS));

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_decode
      assign slot_onehot[i] = (slot_idx == SLOT_AW'(i));
   end

   // Only the latched slot's ack/data are observed; other slots are ignored.
   always_comb begin
      sel_data = '0;
      sel_ack  = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (slot_idx == SLOT_AW'(i)) begin
            sel_data = slot_read_data[i];
            sel_ack  = slot_ack[i];
         end
      end
   end

`ifdef MMIO_TIMEOUT_EN
   logic expired;

   mmio_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (state == IDLE),
      .enable  (state == WAIT),
      .expired (expired)
   );

   // An ack in the final WAIT cycle still wins over the timeout.
   assign timed_out = expired & ~sel_ack;
   assign unused_ok = ^mmio_address[ADDR_W-1:REG_AW+SLOT_AW];
`else
   assign timed_out = 1'b0;
   assign unused_ok = ^{mmio_address[ADDR_W-1:REG_AW+SLOT_AW], (TIMEOUT > 0)};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      slot_cs    = '0;
      slot_write = '0;
      slot_read  = '0;
      mmio_ready = 1'b0;
      mmio_error = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) state_next = bad_req ? DONE : ACCESS;
         end
         ACCESS: begin
            slot_cs = slot_onehot;
            if (op_read) slot_read  = slot_onehot;
            else         slot_write = slot_onehot;
            state_next = sel_ack ? DONE : WAIT;
         end
         WAIT: begin
            slot_cs = slot_onehot;
            if (sel_ack || timed_out) state_next = DONE;
         end
         DONE: begin
            mmio_ready = 1'b1;
            mmio_error = err_flag;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latch and response capture; the read-data register is only
   // written on the edge into DONE so it holds between transactions.
   always_ff @(posedge clock) begin
      if (reset) begin
         slot_idx        <= '0;
         slot_reg_addr   <= '0;
         slot_write_data <= '0;
         op_read         <= 1'b0;
         err_flag        <= 1'b0;
         mmio_read_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  slot_idx        <= req_slot;
                  slot_reg_addr   <= mmio_address[REG_AW-1:0];
                  slot_write_data <= mmio_write_data;
                  op_read         <= mmio_read;
                  err_flag        <= bad_req;
                  if (bad_req) mmio_read_data <= MMIO_ERR_DATA[DW-1:0];
               end
            end
            ACCESS, WAIT: begin
               if (sel_ack) begin
                  err_flag       <= 1'b0;
                  mmio_read_data <= op_read ? sel_data : MMIO_ERR_DATA[DW-1:0];
               end else if (timed_out) begin
                  err_flag       <= 1'b1;
                  mmio_read_data <= MMIO_ERR_DATA[DW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign mmio_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mmio_bus_ctrl
//   Self-checking bench for mmio_bus_ctrl (N_SLOTS=16, TIMEOUT=8). Each
//   transaction's expected cycle-by-cycle behaviour is derived from its
//   outcome (ok / error / timeout) and latency, with random acks on other
//   slots and random requests issued while busy.
//   Revision: 1.0 - initial release
// ============================================================================
module tb_mmio_bus_ctrl;

   localparam int NS  = 16;
   localparam int TO  = 8;
   localparam int AW  = 21;
   localparam int RAW = 5;
   localparam int SAW = 6;
   localparam int DW  = 32;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   mmio_cs;
   logic [AW-1:0]          mmio_address;
   logic [DW-1:0]          mmio_write_data;
   logic                   mmio_write;
   logic                   mmio_read;
   logic [DW-1:0]          mmio_read_data;
   logic                   mmio_ready;
   logic                   mmio_error;
   logic                   mmio_busy;
   logic [NS-1:0]          slot_cs;
   logic [RAW-1:0]         slot_reg_addr;
   logic [DW-1:0]          slot_write_data;
   logic [NS-1:0]          slot_write;
   logic [NS-1:0]          slot_read;
   logic [NS-1:0][DW-1:0]  slot_read_data;
   logic [NS-1:0]          slot_ack;

   int n_checks = 0;
   int n_pass   = 0;

   // Model of the values the bridge-facing registers currently hold.
   logic [DW-1:0]  m_rdata;
   logic [RAW-1:0] m_reg;
   logic [DW-1:0]  m_wdata;

   always #5 clock = ~clock;

   mmio_bus_ctrl #(
      .N_SLOTS (NS), .ADDR_W (AW), .REG_AW (RAW), .SLOT_AW (SAW),
      .DW (DW), .TIMEOUT (TO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .mmio_cs         (mmio_cs),
      .mmio_address    (mmio_address),
      .mmio_write_data (mmio_write_data),
      .mmio_write      (mmio_write),
      .mmio_read       (mmio_read),
      .mmio_read_data  (mmio_read_data),
      .mmio_ready      (mmio_ready),
      .mmio_error      (mmio_error),
      .mmio_busy       (mmio_busy),
      .slot_cs         (slot_cs),
      .slot_reg_addr   (slot_reg_addr),
      .slot_write_data (slot_write_data),
      .slot_write      (slot_write),
      .slot_read       (slot_read),
      .slot_read_data  (slot_read_data),
      .slot_ack        (slot_ack)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One transaction issued at cycle c=0; ack for the target slot appears
   // in cycle 1+d (d=0 means during the strobe cycle).
   task automatic run_txn(input string name, input bit rd, input bit wr,
                          input int slot, input int ra, input logic [DW-1:0] wd,
                          input logic [DW-1:0] tgt_data, input int d, input bit noise);
      bit            err, tmo;
      int            lat, last;
      logic [DW-1:0] exp_rd, e_rdata;
      logic [NS-1:0] tgt;
      logic [3*NS+2:0] e_v, o_v;
      logic [RAW+DW-1:0] e_lat, o_lat;
      err = (rd && wr) || (slot >= NS);
      tmo = 1'b0;
`ifdef MMIO_TIMEOUT_EN
      tmo = !err && (d > TO);
`endif
      lat  = err ? 1 : (tmo ? 2 + TO : 2 + d);
      last = (!err && (d + 2 > lat + 1)) ? d + 2 : lat + 1;
      tgt  = (slot < NS) ? (NS'(1) << slot) : '0;
      for (int i = 0; i < NS; i++) slot_read_data[i] = $urandom;
      if (slot < NS) slot_read_data[slot] = tgt_data;
      exp_rd = (!err && !tmo && rd) ? tgt_data : '0;

      for (int c = 0; c <= last; c++) begin
         if (c == 0) begin
            mmio_cs         = 1'b1;
            mmio_read       = rd;
            mmio_write      = wr;
            mmio_write_data = wd;
            mmio_address    = {10'($urandom), SAW'(slot), RAW'(ra)};
         end else begin
            mmio_cs         = noise && (c <= lat);
            mmio_read       = 1'b1;
            mmio_write      = 1'($urandom);
            mmio_write_data = $urandom;
            mmio_address    = AW'($urandom);
         end
         slot_ack = NS'($urandom) & ~tgt;
         if (!err && c == 1 + d) slot_ack = slot_ack | tgt;

         e_v = '0;
         e_v[3*NS+2] = (c >= 1) && (c <= lat);
         e_v[3*NS+1] = (c == lat);
         e_v[3*NS]   = (c == lat) && (err || tmo);
         if (!err && c >= 1 && c < lat) e_v[3*NS-1 -: NS] = tgt;
         if (!err && c == 1) begin
            if (wr) e_v[2*NS-1 -: NS] = tgt;
            else    e_v[NS-1:0]       = tgt;
         end
         o_v = {mmio_busy, mmio_ready, mmio_error & mmio_ready,
                slot_cs, slot_write, slot_read};
         n_checks++;
         if (o_v !== e_v) $display("FAIL %s c=%0d ctl: got %h want %h", name, c, o_v, e_v);
         else n_pass++;

         e_rdata = (c >= lat) ? exp_rd : m_rdata;
         n_checks++;
         if (mmio_read_data !== e_rdata)
            $display("FAIL %s c=%0d rdata: got %h want %h", name, c, mmio_read_data, e_rdata);
         else n_pass++;

         e_lat = (c >= 1) ? {RAW'(ra), wd} : {m_reg, m_wdata};
         o_lat = {slot_reg_addr, slot_write_data};
         n_checks++;
         if (o_lat !== e_lat)
            $display("FAIL %s c=%0d latch: got %h want %h", name, c, o_lat, e_lat);
         else n_pass++;

         tick();
      end
      mmio_cs  = 1'b0;
      slot_ack = '0;
      m_rdata  = exp_rd;
      m_reg    = RAW'(ra);
      m_wdata  = wd;
   endtask

   task automatic test_reset();
      logic [3*NS+2+DW+RAW+DW:0] o;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mmio_cs = 1'b1; mmio_read = 1'b1; mmio_write = 1'b0;
         mmio_address = AW'($urandom); mmio_write_data = $urandom;
         slot_ack = NS'($urandom);
         tick();
         o = {mmio_busy, mmio_ready, mmio_error, slot_cs, slot_write, slot_read,
              mmio_read_data, slot_reg_addr, slot_write_data, 1'b0};
         n_checks++;
         if (o !== '0) $display("FAIL reset k=%0d outputs: got %h want 0", k, o);
         else n_pass++;
      end
      mmio_cs = 1'b0; slot_ack = '0;
      reset = 1'b0;
      m_rdata = '0; m_reg = '0; m_wdata = '0;
      tick();
   endtask

   task automatic test_write_basic();
      run_txn("write_s3", 1'b0, 1'b1, 3, 7, 32'hA5A5_0001, 32'h0, 0, 1'b0);
   endtask

   task automatic test_read_wait();
      run_txn("read_s10_wait4", 1'b1, 1'b0, 10, 2, 32'h0, 32'h1234_5678, 4, 1'b0);
   endtask

   task automatic test_bad_slot();
      run_txn("read_s20_bad", 1'b1, 1'b0, 20, 1, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
      run_txn("write_s63_bad", 1'b0, 1'b1, 63, 31, 32'h5555_AAAA, 32'h0, 0, 1'b0);
   endtask

   task automatic test_protocol_err();
      run_txn("rd_and_wr", 1'b1, 1'b1, 4, 9, 32'h0BAD_0BAD, 32'hCAFE_F00D, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 40; k++) begin
         bit rd, wr;
         int slot;
         rd   = 1'($urandom);
         wr   = ($urandom_range(0, 9) == 0) ? 1'b1 : !rd;
         slot = ($urandom_range(0, 7) == 0) ? $urandom_range(NS, 63) : $urandom_range(0, NS - 1);
         run_txn("random", rd, wr, slot, $urandom_range(0, 31), $urandom, $urandom,
                 $urandom_range(0, 5), 1'($urandom));
      end
   endtask

`ifdef MMIO_TIMEOUT_EN
   task automatic test_timeout();
      run_txn("timeout_late_ack", 1'b1, 1'b0, 7, 4, 32'h0, 32'h7777_7777, TO + 2, 1'b0);
      run_txn("ack_last_wait", 1'b1, 1'b0, 8, 5, 32'h0, 32'h8888_0001, TO, 1'b0);
   endtask
`endif

   task automatic test_reset_mid();
      logic [3*NS+2+DW+RAW+DW:0] o;
      logic [NS+1:0] ov, ev;
      mmio_cs = 1'b1; mmio_read = 1'b1; mmio_write = 1'b0;
      mmio_address = {10'h0, 6'd5, 5'd9}; mmio_write_data = 32'h1111_2222;
      slot_ack = '0;
      tick();
      mmio_cs = 1'b0;
      tick();
      tick();
      ov = {mmio_busy, mmio_ready, slot_cs};
      ev = {1'b1, 1'b0, NS'(1) << 5};
      n_checks++;
      if (ov !== ev) $display("FAIL reset_mid pre: got %h want %h", ov, ev);
      else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      o = {mmio_busy, mmio_ready, mmio_error, slot_cs, slot_write, slot_read,
           mmio_read_data, slot_reg_addr, slot_write_data, 1'b0};
      n_checks++;
      if (o !== '0) $display("FAIL reset_mid outputs: got %h want 0", o);
      else n_pass++;
      slot_ack = NS'(1) << 5;
      tick();
      slot_ack = '0;
      ov = {mmio_busy, mmio_ready, slot_cs};
      n_checks++;
      if (ov !== '0) $display("FAIL reset_mid no_ready: got %h want 0", ov);
      else n_pass++;
      m_rdata = '0; m_reg = '0; m_wdata = '0;
      run_txn("post_reset_write", 1'b0, 1'b1, 6, 3, 32'h600D_0003, 32'h0, 1, 1'b0);
   endtask

   initial begin
      reset = 1'b1; mmio_cs = 1'b0; mmio_read = 1'b0; mmio_write = 1'b0;
      mmio_address = '0; mmio_write_data = '0; slot_ack = '0; slot_read_data = '0;
      test_reset();
      test_write_basic();
      test_read_wait();
      test_bad_slot();
      test_protocol_err();
      test_back_to_back();
`ifdef MMIO_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised, transaction-based successor to the flat broadcast MMIO decoder.
- Sits between the fpro bridge and N peripheral slots.
- Accepts one read or write at a time, strobes only the addressed slot, and waits for a per-slot acknowledge.
- Returns registered read data with a ready pulse and an error flag for bad slot addresses, protocol violations or timeouts.

Parameters:
- N_SLOTS, 64, number of slots (1..64)
- ADDR_W, 21, bridge address width
- REG_AW, 5, register-address bits per slot (address[REG_AW-1:0])
- SLOT_AW, 6, slot-index bits (address[REG_AW +: SLOT_AW])
- DW, 32, data width
- TIMEOUT, 255, max cycles waiting for slot_ack (used only with MMIO_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mmio_cs  in  1  bridge chip select
- mmio_address  in  ADDR_W  bridge address
- mmio_write_data  in  DW  write data
- mmio_write  in  1  write request
- mmio_read  in  1  read request
- mmio_read_data  out  DW  registered read data
- mmio_ready  out  1  one-cycle transaction-complete pulse
- mmio_error  out  1  error status, valid with mmio_ready
- mmio_busy  out  1  transaction in flight; new requests ignored
- slot_cs  out  N_SLOTS  one-hot select
- slot_reg_addr  out  REG_AW  latched register address (shared)
- slot_write_data  out  DW  latched write data (shared)
- slot_write  out  N_SLOTS  one-hot write strobe
- slot_read  out  N_SLOTS  one-hot read strobe
- slot_read_data  in  DW x N_SLOTS  per-slot read data
- slot_ack  in  N_SLOTS  per-slot completion

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`. In reset, every output is 0 and the FSM goes to IDLE.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Trigger is mmio_cs & (mmio_read | mmio_write).
  - On trigger, latch address, write data and op.
  - If mmio_read & mmio_write, or slot index >= N_SLOTS: set err, go to DONE with no slot activity.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive slot_cs[s], plus slot_write[s] or slot_read[s], for the latched slot s only. All other bits are 0.
  - Sample slot_ack[s]. If high, capture slot_read_data[s] (reads) and go to DONE. Else go to WAIT.
- WAIT:
  - Hold slot_cs[s] high; strobes are 0 (strobe is single-cycle).
  - On slot_ack[s]: capture data, go to DONE.
  - Acks from other slots are ignored.
- DONE (1 cycle):
  - mmio_ready=1; mmio_error=err.
  - mmio_read_data = captured data for a successful read, 0 on error or write.
  - Next state is IDLE.
  - mmio_read_data holds its value until the next DONE.
- mmio_busy = (state != IDLE).
- Requests arriving while busy are dropped, not queued.
- Latency: a request accepted at cycle T with ack at T+1 gives mmio_ready at T+2. Each WAIT cycle adds 1.
- Bad-slot or protocol error: mmio_ready at T+1.
- A reset asserted mid-transaction aborts it with no ready pulse; strobes drop the next edge.
- slot_reg_addr and slot_write_data stay stable from ACCESS through DONE.

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- When defined:
  - An 8-bit+ counter clears on entering ACCESS and increments in WAIT.
  - When it reaches TIMEOUT without an ack: go to DONE with mmio_error=1 and read data 0.
  - A late ack after that is ignored.
- When undefined: WAIT lasts until ack (may hang); the counter logic is absent.

Decomposition:
- Package mmio_pkg holds:
  - typedef enum logic [1:0] mmio_state_t {IDLE, ACCESS, WAIT, DONE}
  - localparam for the slot-index width function
  - constant MMIO_ERR_DATA = '0
- One sub-module, mmio_timeout: counter with clear/enable/expired. It is instantiated only under MMIO_TIMEOUT_EN.
- Decode and mux stay inline.

Test Plan:
- Write slot 3, reg 7, data 0xA5A5_0001, slot_ack[3] at ACCESS -> slot_write = 1<<3 for one cycle, slot_reg_addr=7, mmio_ready at T+2, mmio_error=0.
- Read slot 10 with slot_read_data[10]=0x1234_5678 and ack after 4 WAIT cycles -> slot_read[10] pulses once, slot_cs[10] held 5 cycles, mmio_read_data=0x1234_5678, ready at T+6.
- N_SLOTS=16, read slot 20 -> no slot_cs/strobe activity, ready at T+1, mmio_error=1, data 0.
- mmio_read & mmio_write both high -> error at T+1. A second request issued while busy is ignored (exactly one ready pulse).
- MMIO_TIMEOUT_EN, TIMEOUT=8, no ack -> ready with error after 8 WAIT cycles. An ack arriving 2 cycles later produces no extra ready.
- Reset asserted during WAIT -> next cycle all outputs 0, no ready. A following write completes normally.
